execute_muldiv: RTL

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_core.sv | 77 +++++++
 rtl/execute_muldiv.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings, state enumeration and helpers for the iterative multiply/divide unit.
// The divider state and the DIV/DIVU codes only take effect when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam int ITER_COUNT = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
        DIV  = 2'd2,
`endif
        FIN  = 2'd3
    } state_t;

    function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Unsigned shift-add multiplier / restoring divider sharing one {acc_hi, acc_lo} register pair.
// The divider path exists only when MULDIV_DIV_EN is defined.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             clr,
    input  logic             load,
    input  logic             run,
`ifdef MULDIV_DIV_EN
    input  logic             div_mode,
`endif
    input  logic [WIDTH-1:0] load_lo,
    input  logic [WIDTH-1:0] load_opnd,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo,
    output logic             last
);

    logic [WIDTH-1:0] acc_hi_reg, acc_lo_reg, opnd_reg;
    logic [WIDTH-1:0] acc_hi_next, acc_lo_next;
    logic [4:0]       cnt_reg;
    logic [WIDTH:0]   mul_wide;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
`endif

    assign acc_hi = acc_hi_reg;
    assign acc_lo = acc_lo_reg;
    assign last   = (cnt_reg == 5'(ITER_COUNT - 1));

    always_comb begin
        // Multiply: conditionally add the multiplicand, then shift {carry, hi, lo} right.
        mul_wide = acc_lo_reg[0] ? ({1'b0, acc_hi_reg} + {1'b0, opnd_reg}) : {1'b0, acc_hi_reg};
        {acc_hi_next, acc_lo_next} = {mul_wide, acc_lo_reg[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        // Divide: shift the next dividend bit into the remainder and try subtracting.
        div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
        div_diff  = div_shift[WIDTH-1:0] - opnd_reg;
        if (div_mode) begin
            if (div_shift >= {1'b0, opnd_reg}) begin
                acc_hi_next = div_diff;
                acc_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_next = div_shift[WIDTH-1:0];
                acc_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            opnd_reg   <= '0;
            cnt_reg    <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (load) begin
            acc_hi_reg <= '0;
            acc_lo_reg <= load_lo;
            opnd_reg   <= load_opnd;
            cnt_reg    <= '0;
        end else if (run) begin
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            if (!last)
                cnt_reg <= cnt_reg + 5'd1;
        end
    end

endmodule

// File: rtl/execute_muldiv.sv
// Execute-stage HI/LO unit: control FSM, operand sign handling and architectural HI/LO.
// Define MULDIV_DIV_EN to include DIV/DIVU; otherwise those codes are ignored.
module execute_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             StartE,
    input  logic [2:0]       OpE,
    input  logic [WIDTH-1:0] ReadData1E,
    input  logic [WIDTH-1:0] ReadData2E,
    input  logic             FlushE,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    state_t           state_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             busy_reg, done_reg, neg_lo_reg;
`ifdef MULDIV_DIV_EN
    logic             is_div_reg, div0_reg, neg_hi_reg;
    logic             is_div_op, div_by_zero;
`endif
    logic             is_mul_op, op_signed, accept;
    logic [WIDTH-1:0] mag_a, mag_b, load_lo, load_opnd;
    logic             core_load, core_run, core_last;
    logic [WIDTH-1:0] core_hi, core_lo, fin_hi, fin_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign Busy  = busy_reg;
    assign Done  = done_reg;
    assign HiOut = hi_reg;
    assign LoOut = lo_reg;

    always_comb begin
        is_mul_op = (OpE == OP_MULT) || (OpE == OP_MULTU);
        op_signed = (OpE == OP_MULT) || (OpE == OP_DIV);
        mag_a     = magnitude(ReadData1E, op_signed);
        mag_b     = magnitude(ReadData2E, op_signed);
        accept    = StartE && !FlushE && (state_reg == IDLE);
        load_lo   = mag_b;
        load_opnd = mag_a;
        core_load = accept && is_mul_op;
        core_run  = !FlushE && (state_reg == MUL);
`ifdef MULDIV_DIV_EN
        is_div_op   = (OpE == OP_DIV) || (OpE == OP_DIVU);
        div_by_zero = (ReadData2E == '0);
        if (!is_mul_op) begin
            // A zero divisor parks the raw dividend so FIN can hand it straight to HI.
            load_lo   = div_by_zero ? ReadData1E : mag_a;
            load_opnd = mag_b;
        end
        core_load = accept && (is_mul_op || is_div_op);
        core_run  = !FlushE && ((state_reg == MUL) || (state_reg == DIV));
`endif
    end

    always_comb begin
        prod     = {core_hi, core_lo};
        prod_fix = neg_lo_reg ? (~prod + 1'b1) : prod;
        fin_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fin_lo   = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (is_div_reg) begin
            if (div0_reg) begin
                fin_hi = core_lo;
                fin_lo = '1;
            end else begin
                fin_lo = neg_lo_reg ? (~core_lo + 1'b1) : core_lo;
                fin_hi = neg_hi_reg ? (~core_hi + 1'b1) : core_hi;
            end
        end
`endif
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .Clk       (Clk),
        .Rst       (Rst),
        .clr       (FlushE),
        .load      (core_load),
        .run       (core_run),
`ifdef MULDIV_DIV_EN
        .div_mode  (state_reg == DIV),
`endif
        .load_lo   (load_lo),
        .load_opnd (load_opnd),
        .acc_hi    (core_hi),
        .acc_lo    (core_lo),
        .last      (core_last)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg  <= IDLE;
            hi_reg     <= '0;
            lo_reg     <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            neg_lo_reg <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_reg <= 1'b0;
            div0_reg   <= 1'b0;
            neg_hi_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (FlushE) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (StartE) begin
                            if (is_mul_op) begin
                                neg_lo_reg <= op_signed && (ReadData1E[WIDTH-1] ^ ReadData2E[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                                is_div_reg <= 1'b0;
`endif
                                state_reg  <= MUL;
                                busy_reg   <= 1'b1;
`ifdef MULDIV_DIV_EN
                            end else if (is_div_op) begin
                                is_div_reg <= 1'b1;
                                div0_reg   <= div_by_zero;
                                neg_lo_reg <= op_signed && !div_by_zero &&
                                              (ReadData1E[WIDTH-1] ^ ReadData2E[WIDTH-1]);
                                neg_hi_reg <= op_signed && !div_by_zero && ReadData1E[WIDTH-1];
                                state_reg  <= div_by_zero ? FIN : DIV;
                                busy_reg   <= 1'b1;
`endif
                            end else if (OpE == OP_MTHI) begin
                                hi_reg <= ReadData1E;
                            end else if (OpE == OP_MTLO) begin
                                lo_reg <= ReadData1E;
                            end
                        end
                    end
                    MUL: begin
                        if (core_last)
                            state_reg <= FIN;
                    end
`ifdef MULDIV_DIV_EN
                    DIV: begin
                        if (core_last)
                            state_reg <= FIN;
                    end
`endif
                    FIN: begin
                        hi_reg    <= fin_hi;
                        lo_reg    <= fin_lo;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule
